// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter that lets two requesters share one
// external combinational 8x8 multiplier. A granted operand pair is registered
// onto mul_a/mul_b, held for SETTLE_CYCLES cycles, and then the product is
// captured and returned on a valid/ready response channel.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      operand handshake per requester (ready is combinational)
//   req{0,1}_a, req{0,1}_b     8-bit unsigned operands
//   mul_a, mul_b               registered operands to the shared multiplier
//   mul_prod                   combinational product from the shared multiplier
//   rsp_valid, rsp_ready       result handshake
//   rsp_id, rsp_prod           owner and value of the registered product
//   busy                       high whenever not idle
//   done_cnt                   wrapping count of completed responses
module mult_share_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_prod,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_prod,
  output logic        busy,
  output logic [7:0]  done_cnt
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_prod_q, rsp_prod_d;
  logic [7:0]  done_cnt_q, done_cnt_d;
  logic        grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_prod_q   <= '0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_prod_q   <= rsp_prod_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_prod_d   = rsp_prod_q;
    done_cnt_d   = done_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // On a tie the requester that did not win last time goes; otherwise the lone one.
    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          last_grant_d = grant;
          mul_a_d      = grant ? req1_a : req0_a;
          mul_b_d      = grant ? req1_b : req0_b;
          rsp_id_d     = grant;
          cnt_d        = 4'(SETTLE_CYCLES);
          state_d      = StCalc;
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_prod_d = mul_prod;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign done_cnt  = done_cnt_q;
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule
